// File: rtl/ptype_pkg.sv
// Shared definitions for the ptype narrow-link serializer/deserializer pair.
// Holds the beat-count helper so both ends agree on how a word is split.
package ptype_pkg;

   typedef logic [7:0] foo_t;

   localparam int DEFAULT_BEAT_W = 8;

   // Ceiling division; a nonsensical beat width collapses to one beat so elaboration can report it
   function automatic int nbeats(input int dw, input int bw);
      if (bw < 1) return 1;
      return (dw + bw - 1) / bw;
   endfunction

endpackage

// File: rtl/ptype_ser.sv
// Transmit serializer: takes one TYPE_T word per handshake and emits it as BEAT_W-bit beats,
// LSB beat first, flagging the final beat; reloads on the last beat for back-to-back words.
import ptype_pkg::*;

module ptype_ser #(
   parameter int  WIDTH  = 1,
   parameter type TYPE_T = logic [WIDTH-1:0],
   parameter int  BEAT_W = DEFAULT_BEAT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  TYPE_T             in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [BEAT_W-1:0] out_data,
   output logic              out_last,
   output logic              busy
);

   localparam int DW     = $bits(TYPE_T);
   localparam int NBEATS = nbeats(DW, BEAT_W);
   localparam int CW     = (NBEATS > 1) ? $clog2(NBEATS) : 1;
   localparam int PW     = NBEATS * BEAT_W;

   if (BEAT_W < 1 || BEAT_W > DW) begin : g_bad_beat_w
      $error("ptype_ser: BEAT_W must lie in 1..$bits(TYPE_T)");
   end

   typedef enum logic {IDLE, SEND} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [PW-1:0]   hold;
   logic [DW-1:0]   in_bits;
   logic            last;
   logic            load;
   logic            shift;

   assign in_bits = in_data;
   assign last    = (state == SEND) && (cnt == CW'(NBEATS - 1));

   // The hold register shifts down each beat, so the current beat always sits in the low bits
   assign out_valid = (state == SEND);
   assign busy      = out_valid;
   assign out_last  = last;
   assign out_data  = hold[BEAT_W-1:0];
   assign in_ready  = (state == IDLE) || (last && out_ready);

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      load    = 1'b0;
      shift   = 1'b0;
      case (state)
         IDLE: begin
            if (in_valid) begin
               load    = 1'b1;
               cnt_n   = '0;
               state_n = SEND;
            end
         end
         SEND: begin
            if (out_ready) begin
               if (!last) begin
                  cnt_n = cnt + CW'(1);
                  shift = 1'b1;
               end else if (in_valid) begin
                  load  = 1'b1;
                  cnt_n = '0;
               end else begin
                  cnt_n   = '0;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         hold  <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (load) begin
            hold <= PW'(in_bits);
         end else if (shift) begin
            hold <= hold >> BEAT_W;
         end
      end
   end

endmodule

// File: tb/tb_ptype_ser.sv
// Directed bench for ptype_ser: 20-bit words over 8-bit beats, an 8-bit word in a
// one-beat slice under random backpressure, and a 20-bit word in a single 20-bit beat.
module tb_ptype_ser;
   import ptype_pkg::*;

   logic clk;
   logic rst;

   logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
   logic [19:0] a_in_data;
   logic [7:0]  a_out_data;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
   foo_t        b_in_data;
   logic [7:0]  b_out_data;

   logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_last, c_busy;
   logic [19:0] c_in_data;
   logic [19:0] c_out_data;

   int checks = 0;
   int errors = 0;

   ptype_ser #(.TYPE_T(logic [19:0]), .BEAT_W(8)) dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
      .out_last(a_out_last), .busy(a_busy)
   );

   ptype_ser #(.TYPE_T(foo_t), .BEAT_W(8)) dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
      .out_last(b_out_last), .busy(b_busy)
   );

   ptype_ser #(.TYPE_T(logic [19:0]), .BEAT_W(20)) dut_c (
      .clk(clk), .rst(rst),
      .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
      .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
      .out_last(c_out_last), .busy(c_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [19:0] data, input logic ready);
      a_in_valid  = valid;
      a_in_data   = data;
      a_out_ready = ready;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkBeatA(input string tag, input logic [7:0] data, input logic last,
                             input logic rdy);
      checkOutput({tag, "_valid"}, 32'(a_out_valid), 32'd1);
      checkOutput({tag, "_data"},  32'(a_out_data),  32'(data));
      checkOutput({tag, "_last"},  32'(a_out_last),  32'(last));
      checkOutput({tag, "_ready"}, 32'(a_in_ready),  32'(rdy));
   endtask

   logic [7:0] seq2 [9];
   foo_t       words [12];

   initial begin
      int sent, recv, cyc;

      seq2 = '{8'h11, 8'h11, 8'h01, 8'h22, 8'h22, 8'h02, 8'h33, 8'h33, 8'h03};
      for (int i = 0; i < 12; i++) words[i] = foo_t'(i * 37 + 5);

      rst = 1'b1;
      applyStimulus(1'b0, 20'h0, 1'b0);
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0;
      c_in_valid = 1'b0; c_in_data = '0; c_out_ready = 1'b0;
      #12;
      checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
      checkOutput("rst_busy",      32'(a_busy),      32'd0);
      checkOutput("rst_out_last",  32'(a_out_last),  32'd0);
      checkOutput("rst_in_ready",  32'(a_in_ready),  32'd1);
      checkOutput("rst_out_data",  32'(a_out_data),  32'd0);
      tick();
      rst = 1'b0;

      // Single word, three beats, top nibble of the last beat zero-padded
      applyStimulus(1'b1, 20'hABCDE, 1'b1);
      tick();
      a_in_valid = 1'b0;
      #1;
      checkBeatA("w1_b0", 8'hDE, 1'b0, 1'b0);
      tick();
      checkBeatA("w1_b1", 8'hBC, 1'b0, 1'b0);
      tick();
      checkBeatA("w1_b2", 8'h0A, 1'b1, 1'b1);
      tick();
      checkOutput("w1_idle_valid", 32'(a_out_valid), 32'd0);
      checkOutput("w1_idle_ready", 32'(a_in_ready),  32'd1);

      // Three words back to back with in_valid held high: nine beats, no gap
      applyStimulus(1'b1, 20'h11111, 1'b1);
      tick();
      for (int k = 0; k < 9; k++) begin
         checkBeatA($sformatf("b2b_%0d", k), seq2[k], (k % 3) == 2, (k % 3) == 2);
         if (k == 2) a_in_data = 20'h22222;
         if (k == 5) a_in_data = 20'h33333;
         if (k == 8) a_in_valid = 1'b0;
         tick();
      end
      checkOutput("b2b_idle_valid", 32'(a_out_valid), 32'd0);

      // Backpressure in the middle of beat 1
      applyStimulus(1'b1, 20'hABCDE, 1'b1);
      tick();
      a_in_valid = 1'b0;
      #1;
      checkBeatA("bp_b0", 8'hDE, 1'b0, 1'b0);
      tick();
      a_out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         checkBeatA($sformatf("bp_hold%0d", k), 8'hBC, 1'b0, 1'b0);
         tick();
      end
      a_out_ready = 1'b1;
      #1;
      checkBeatA("bp_b1", 8'hBC, 1'b0, 1'b0);
      tick();
      checkBeatA("bp_b2", 8'h0A, 1'b1, 1'b1);
      tick();
      checkOutput("bp_idle_valid", 32'(a_out_valid), 32'd0);

      // One-beat slice under random backpressure: every word once, in order
      sent = 0;
      recv = 0;
      cyc  = 0;
      while (recv < 12 && cyc < 300) begin
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_valid  = (sent < 12);
         b_in_data   = (sent < 12) ? words[sent] : foo_t'(8'hEE);
         #1;
         checkOutput("slice_ready", 32'(b_in_ready), 32'(!b_busy || b_out_ready));
         if (b_out_valid && b_out_ready) begin
            checkOutput($sformatf("slice_data%0d", recv), 32'(b_out_data), 32'(words[recv]));
            checkOutput("slice_last", 32'(b_out_last), 32'd1);
            recv++;
         end
         if (b_in_valid && b_in_ready) sent++;
         tick();
         cyc++;
      end
      b_in_valid = 1'b0;
      checkOutput("slice_count", 32'(recv), 32'd12);
      b_out_ready = 1'b1;
      tick();
      checkOutput("slice_idle_valid", 32'(b_out_valid), 32'd0);

      // Reset during beat 1 drops the word at once
      applyStimulus(1'b1, 20'hFFFFF, 1'b1);
      tick();
      a_in_valid = 1'b0;
      tick();
      #1;
      checkOutput("mid_pre_data", 32'(a_out_data), 32'hFF);
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_valid", 32'(a_out_valid), 32'd0);
      checkOutput("mid_rst_ready", 32'(a_in_ready),  32'd1);
      checkOutput("mid_rst_data",  32'(a_out_data),  32'd0);
      tick();
      rst = 1'b0;
      applyStimulus(1'b1, 20'h00001, 1'b1);
      tick();
      a_in_valid = 1'b0;
      #1;
      checkBeatA("post_b0", 8'h01, 1'b0, 1'b0);
      tick();
      checkBeatA("post_b1", 8'h00, 1'b0, 1'b0);
      tick();
      checkBeatA("post_b2", 8'h00, 1'b1, 1'b1);
      tick();

      // Whole word in a single 20-bit beat
      c_in_valid  = 1'b1;
      c_in_data   = 20'hFFFFF;
      c_out_ready = 1'b1;
      tick();
      c_in_valid = 1'b0;
      #1;
      checkOutput("wide_valid", 32'(c_out_valid), 32'd1);
      checkOutput("wide_data",  32'(c_out_data),  32'hFFFFF);
      checkOutput("wide_last",  32'(c_out_last),  32'd1);
      checkOutput("wide_ready", 32'(c_in_ready),  32'd1);
      c_out_ready = 1'b0;
      #1;
      checkOutput("wide_stall_ready", 32'(c_in_ready), 32'd0);
      c_out_ready = 1'b1;
      tick();
      checkOutput("wide_idle_valid", 32'(c_out_valid), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
